// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state encoding and op classification helpers
// for the EX-stage iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_MULH  = 3'b001;
  localparam logic [2:0] OP_MULHU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MOD   = 3'b100;
  localparam logic [2:0] OP_DIVU  = 3'b101;
  localparam logic [2:0] OP_MODU  = 3'b110;
  localparam logic [2:0] OP_RSV   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op >= OP_DIV) && (op != OP_RSV);
  endfunction

endpackage

// File: rtl/muldiv_iter_datapath.sv
// Shift registers for one shift-add multiply or restoring-divide step
// per enable; operates on magnitudes only, sign handling lives in the top.
module muldiv_iter_datapath
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              step,
  input  logic [2:0]        op,
  input  logic [XLEN-1:0]   a_mag,
  input  logic [XLEN-1:0]   b_mag,
  output logic [2*XLEN-1:0] product,
  output logic [XLEN-1:0]   quotient,
  output logic [XLEN-1:0]   remainder
);

  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN:0]     sum;
  logic [XLEN+1:0]   shifted, diff;
  logic              is_div;

  always_comb begin
    is_div  = is_div_op(op);
    prod_d  = prod_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    opnd_d  = opnd_q;
    sum     = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {2'b00, opnd_q};
    if (load) begin
      // opnd holds the multiplicand for mul, the divisor for div
      opnd_d = is_div ? b_mag : a_mag;
      prod_d = {{XLEN{1'b0}}, b_mag};
      quo_d  = a_mag;
      rem_d  = '0;
    end else if (step) begin
      if (is_div) begin
        rem_d = diff[XLEN+1] ? shifted[XLEN:0] : diff[XLEN:0];
        quo_d = {quo_q[XLEN-2:0], ~diff[XLEN+1]};
      end else begin
        prod_d = {sum, prod_q[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      prod_q <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      opnd_q <= '0;
    end else begin
      prod_q <= prod_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      opnd_q <= opnd_d;
    end
  end

  assign product   = prod_q;
  assign quotient  = quo_q;
  assign remainder = rem_q[XLEN-1:0];

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: handshake FSM, divide special cases and
// sign fix-up around the iterative magnitude datapath.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [XLEN-1:0]  req_src1,
  input  logic [XLEN-1:0]  req_src2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_result,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              neg_q, neg_d;
  logic              spec_q, spec_d;
  logic [XLEN-1:0]   spec_res_q, spec_res_d;

  logic              accept, dp_load, dp_step;
  logic              src1_neg, src2_neg, div_zero, div_ovf, special;
  logic [2:0]        dp_op;
  logic [XLEN-1:0]   a_mag, b_mag, spec_res;
  logic [XLEN-1:0]   quotient, remainder, quo_fix, rem_fix, result;
  logic [2*XLEN-1:0] product, prod_fix;

  assign req_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && resp_ready);
  assign accept     = req_valid && req_ready && !flush;
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = (state_q == S_DONE);
  assign resp_tag   = tag_q;

  always_comb begin
    src1_neg = is_signed_op(req_op) && req_src1[XLEN-1];
    src2_neg = is_signed_op(req_op) && req_src2[XLEN-1];
    a_mag    = src1_neg ? -req_src1 : req_src1;
    b_mag    = src2_neg ? -req_src2 : req_src2;
    div_zero = is_div_op(req_op) && (req_src2 == '0);
    div_ovf  = ((req_op == OP_DIV) || (req_op == OP_MOD)) &&
               (req_src1 == INT_MIN) && (&req_src2);
    special  = div_zero || div_ovf || (req_op == OP_RSV);
    spec_res = '0;
    if (div_zero) begin
      spec_res = ((req_op == OP_DIV) || (req_op == OP_DIVU)) ? '1 : req_src1;
    end else if (div_ovf) begin
      spec_res = (req_op == OP_DIV) ? req_src1 : '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    tag_d      = tag_q;
    neg_d      = neg_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    dp_load    = 1'b0;
    dp_step    = 1'b0;
    case (state_q)
      S_CALC: begin
        dp_step = 1'b1;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: ;
    endcase
    if (accept) begin
      state_d    = special ? S_DONE : S_CALC;
      cnt_d      = special ? '0 : CW'(XLEN);
      op_d       = req_op;
      tag_d      = req_tag;
      // remainder follows the dividend sign, everything else the sign product
      neg_d      = (req_op == OP_MOD) ? src1_neg : (src1_neg ^ src2_neg);
      spec_d     = special;
      spec_res_d = spec_res;
      dp_load    = !special;
    end
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      dp_step = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= OP_MUL;
      tag_q      <= '0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      tag_q      <= tag_d;
      neg_q      <= neg_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
    end
  end

  assign dp_op = accept ? req_op : op_q;

  muldiv_iter_datapath #(.XLEN(XLEN)) u_datapath (
    .clk       (clk),
    .resetn    (resetn),
    .load      (dp_load),
    .step      (dp_step),
    .op        (dp_op),
    .a_mag     (a_mag),
    .b_mag     (b_mag),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_comb begin
    prod_fix = neg_q ? -product : product;
    quo_fix  = neg_q ? -quotient : quotient;
    rem_fix  = neg_q ? -remainder : remainder;
    case (op_q)
      OP_MUL:            result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHU: result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:   result = quo_fix;
      OP_MOD, OP_MODU:   result = rem_fix;
      default:           result = '0;
    endcase
    if (spec_q) result = spec_res_q;
  end

  assign resp_result = (state_q == S_DONE) ? result : '0;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed literal cases plus a randomized
// handshake/flush sweep on XLEN=32 and XLEN=16 instances against an arithmetic model.
module tb_ex_muldiv_unit;

  localparam int TAG_W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             resetn[2], flush[2], req_valid[2], req_ready[2];
  logic             resp_valid[2], resp_ready[2], busy[2];
  logic [2:0]       req_op[2];
  logic [31:0]      req_src1[2], req_src2[2], resp_result[2];
  logic [TAG_W-1:0] req_tag[2], resp_tag[2];
  logic [31:0]      res32;
  logic [15:0]      res16;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  ex_muldiv_unit #(.XLEN(32), .TAG_W(TAG_W)) u_dut32 (
    .clk(clk), .resetn(resetn[0]), .flush(flush[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
    .req_src1(req_src1[0]), .req_src2(req_src2[0]), .req_tag(req_tag[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_result(res32), .resp_tag(resp_tag[0]), .busy(busy[0])
  );

  ex_muldiv_unit #(.XLEN(16), .TAG_W(TAG_W)) u_dut16 (
    .clk(clk), .resetn(resetn[1]), .flush(flush[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
    .req_src1(req_src1[1][15:0]), .req_src2(req_src2[1][15:0]), .req_tag(req_tag[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_result(res16), .resp_tag(resp_tag[1]), .busy(busy[1])
  );

  assign resp_result[0] = res32;
  assign resp_result[1] = {16'h0000, res16};

  task automatic check(input int d, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL dut%0d %s: got %h expected %h (cycle %0d)", d, name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_res(input int w, input logic [2:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    longint unsigned mask, ua, ub, r;
    longint sa, sb, smin;
    mask = (64'd1 << w) - 64'd1;
    ua   = 64'(a) & mask;
    ub   = 64'(b) & mask;
    sa   = ua[w-1] ? (longint'(ua) - (longint'(1) << w)) : longint'(ua);
    sb   = ub[w-1] ? (longint'(ub) - (longint'(1) << w)) : longint'(ub);
    smin = -(longint'(1) << (w - 1));
    case (op)
      3'd0: r = ua * ub;
      3'd1: r = 64'((sa * sb) >>> w);
      3'd2: r = (ua * ub) >> w;
      3'd3: r = (ub == 0) ? mask : ((sa == smin && sb == -1) ? ua : 64'(sa / sb));
      3'd4: r = (ub == 0) ? ua : ((sa == smin && sb == -1) ? 64'd0 : 64'(sa % sb));
      3'd5: r = (ub == 0) ? mask : ua / ub;
      3'd6: r = (ub == 0) ? ua : ua % ub;
      default: r = 64'd0;
    endcase
    return 32'(r & mask);
  endfunction

  function automatic bit ref_short(input int w, input logic [2:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
    logic [31:0] m, mn;
    m  = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    mn = 32'h1 << (w - 1);
    return (op == 3'd7) || (op >= 3'd3 && op <= 3'd6 && (b & m) == 0) ||
           ((op == 3'd3 || op == 3'd4) && (a & m) == mn && (b & m) == m);
  endfunction

  // Model: at most one op is pending per unit; it becomes visible at a known cycle.
  bit               pend[2];
  int               rdy_cyc[2];
  logic [31:0]      exp_res[2];
  logic [TAG_W-1:0] exp_tag[2];

  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      int w;
      bit ev, er;
      w  = (d == 0) ? 32 : 16;
      ev = pend[d] && (cyc >= rdy_cyc[d]);
      er = !pend[d] || (ev && resp_ready[d]);
      if (chk_en) begin
        check(d, "resp_valid", {31'b0, resp_valid[d]}, {31'b0, ev});
        check(d, "busy", {31'b0, busy[d]}, {31'b0, pend[d]});
        check(d, "req_ready", {31'b0, req_ready[d]}, {31'b0, er});
        if (ev) begin
          check(d, "resp_result", resp_result[d], exp_res[d]);
          check(d, "resp_tag", 32'(resp_tag[d]), 32'(exp_tag[d]));
        end
      end
      if (!resetn[d] || flush[d]) begin
        pend[d] = 1'b0;
      end else begin
        if (ev && resp_ready[d]) pend[d] = 1'b0;
        if (req_valid[d] && er) begin
          pend[d]    = 1'b1;
          rdy_cyc[d] = cyc + (ref_short(w, req_op[d], req_src1[d], req_src2[d]) ? 1 : w + 1);
          exp_res[d] = ref_res(w, req_op[d], req_src1[d], req_src2[d]);
          exp_tag[d] = req_tag[d];
        end
      end
    end
  end

  task automatic issue(input int d, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [TAG_W-1:0] tag, input bit rr);
    @(posedge clk); #1;
    req_valid[d]  = 1'b1;
    req_op[d]     = op;
    req_src1[d]   = a;
    req_src2[d]   = b;
    req_tag[d]    = tag;
    resp_ready[d] = rr;
    flush[d]      = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
  endtask

  task automatic wait_resp(input int d, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid[d] && lat < 200);
    if (!resp_valid[d]) begin
      n_chk++;
      n_fail++;
      $display("FAIL dut%0d response timeout: no resp_valid after %0d cycles", d, lat);
    end
  endtask

  task automatic dir_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] tag,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    issue(0, op, a, b, tag, 1'b1);
    wait_resp(0, lat);
    check(0, {name, " result"}, resp_result[0], exp);
    check(0, {name, " latency"}, 32'(lat), 32'(exp_lat));
    check(0, {name, " tag"}, 32'(resp_tag[0]), 32'(tag));
  endtask

  task automatic check_reset_outputs(input string name);
    check(0, {name, " resp_valid"}, {31'b0, resp_valid[0]}, 32'd0);
    check(0, {name, " req_ready"}, {31'b0, req_ready[0]}, 32'd1);
    check(0, {name, " busy"}, {31'b0, busy[0]}, 32'd0);
    check(0, {name, " resp_result"}, resp_result[0], 32'd0);
    check(0, {name, " resp_tag"}, 32'(resp_tag[0]), 32'd0);
  endtask

  function automatic logic [31:0] pick(input int w);
    logic [31:0] m, v;
    m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'd1;
      2: v = m;
      3: v = 32'h1 << (w - 1);
      4: v = 32'($urandom_range(0, 15));
      5: v = m - 32'($urandom_range(1, 15));
      default: v = $urandom;
    endcase
    return v & m;
  endfunction

  task automatic rand_run(input int d, input int ncyc);
    int w;
    w = (d == 0) ? 32 : 16;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      req_valid[d]  = ($urandom_range(0, 3) != 0);
      req_op[d]     = 3'($urandom_range(0, 7));
      req_src1[d]   = pick(w);
      req_src2[d]   = pick(w);
      req_tag[d]    = TAG_W'($urandom);
      resp_ready[d] = ($urandom_range(0, 3) != 0);
      flush[d]      = ($urandom_range(0, 99) == 0);
    end
    @(posedge clk); #1;
    req_valid[d]  = 1'b0;
    flush[d]      = 1'b0;
    resp_ready[d] = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;
    for (int d = 0; d < 2; d++) begin
      resetn[d] = 1'b0; flush[d] = 1'b0; req_valid[d] = 1'b0; req_op[d] = 3'd0;
      req_src1[d] = '0; req_src2[d] = '0; req_tag[d] = '0; resp_ready[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    resetn[0] = 1'b1;
    resetn[1] = 1'b1;
    chk_en    = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");

    dir_op("divu 7/2", 3'd5, 32'd7, 32'd2, 5'd5, 32'h0000_0003, 33);
    dir_op("modu 7/2", 3'd6, 32'd7, 32'd2, 5'd6, 32'h0000_0001, 33);
    dir_op("mod -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 33);
    dir_op("div -7/2", 3'd3, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFD, 33);
    dir_op("mulh min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd9, 32'h4000_0000, 33);
    dir_op("mulhu ones", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFE, 33);
    dir_op("mul ones", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'h0000_0001, 33);
    dir_op("div by 0", 3'd3, 32'h0000_1234, 32'd0, 5'd12, 32'hFFFF_FFFF, 1);
    dir_op("mod by 0", 3'd4, 32'h0000_1234, 32'd0, 5'd13, 32'h0000_1234, 1);
    dir_op("divu by 0", 3'd5, 32'h0000_1234, 32'd0, 5'd14, 32'hFFFF_FFFF, 1);
    dir_op("modu by 0", 3'd6, 32'h0000_1234, 32'd0, 5'd15, 32'h0000_1234, 1);
    dir_op("div ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1);
    dir_op("mod ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0000_0000, 1);
    dir_op("reserved", 3'd7, 32'h1234_5678, 32'd3, 5'd18, 32'h0000_0000, 1);

    // consumer stalls in DONE, then takes the result while a new op is offered
    issue(0, 3'd5, 32'd100, 32'd7, 5'd9, 1'b0);
    wait_resp(0, lat);
    check(0, "stall latency", 32'(lat), 32'd33);
    repeat (5) begin
      @(negedge clk);
      check(0, "stall resp_valid", {31'b0, resp_valid[0]}, 32'd1);
      check(0, "stall result", resp_result[0], 32'd14);
      check(0, "stall tag", 32'(resp_tag[0]), 32'd9);
      check(0, "stall req_ready", {31'b0, req_ready[0]}, 32'd0);
    end
    @(posedge clk); #1;
    resp_ready[0] = 1'b1;
    req_valid[0]  = 1'b1;
    req_op[0]     = 3'd0;
    req_src1[0]   = 32'd6;
    req_src2[0]   = 32'd7;
    req_tag[0]    = 5'd3;
    @(negedge clk);
    check(0, "back-to-back req_ready", {31'b0, req_ready[0]}, 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_resp(0, lat);
    check(0, "back-to-back latency", 32'(lat), 32'd33);
    check(0, "back-to-back result", resp_result[0], 32'd42);
    check(0, "back-to-back tag", 32'(resp_tag[0]), 32'd3);

    // flush mid-calculation with a competing request in the flush cycle
    issue(0, 3'd3, 32'd1000, 32'd3, 5'd17, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    flush[0]     = 1'b1;
    req_valid[0] = 1'b1;
    req_op[0]    = 3'd0;
    req_src1[0]  = 32'd2;
    req_src2[0]  = 32'd3;
    req_tag[0]   = 5'd18;
    @(posedge clk); #1;
    flush[0]     = 1'b0;
    req_valid[0] = 1'b0;
    @(negedge clk);
    check(0, "flush busy", {31'b0, busy[0]}, 32'd0);
    check(0, "flush resp_valid", {31'b0, resp_valid[0]}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid[0]) seen = 1'b1;
    end
    check(0, "flushed op silent", {31'b0, seen}, 32'd0);
    dir_op("after flush", 3'd5, 32'd1000, 32'd3, 5'd19, 32'd333, 33);

    // synchronous reset pulse mid-calculation
    issue(0, 3'd2, 32'h1234_5678, 32'h9ABC_DEF0, 5'd21, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    resetn[0] = 1'b0;
    @(posedge clk); #1;
    resetn[0] = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid-op reset");
    dir_op("after reset", 3'd0, 32'h0001_0003, 32'h0000_0005, 5'd22, 32'h0005_000F, 33);

    fork
      rand_run(0, 30000);
      rand_run(1, 30000);
    join
    repeat (40) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
